// File: rtl/status_monitor.sv
// status_monitor
//   Tracks a core's status stream: runs a small run-state FSM (IDLE, RUN and
//   three terminal states), counts R-type / I-type events, and queues every
//   accepted event as {code, sequence idx} in a FIFO for a downstream reader.
//
// Ports
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_status[1:0]              0 R-type, 1 I-type, 2 overflow, 3 end
//   i_status_valid             one event per asserted cycle
//   o_evt_valid / i_evt_ready  FIFO head handshake (pop on valid & ready)
//   o_evt_status, o_evt_idx    FIFO head contents (zero when empty)
//   o_cnt_r, o_cnt_i           saturating counts of accepted code 0 / code 1
//   o_state[2:0]               current FSM state
//   o_done                     run terminated (end, overflow or timeout)
//   o_err                      sticky: event after termination or FIFO drop
module status_monitor #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_status,
    input  logic        i_status_valid,
    output logic        o_evt_valid,
    input  logic        i_evt_ready,
    output logic [1:0]  o_evt_status,
    output logic [15:0] o_evt_idx,
    output logic [15:0] o_cnt_r,
    output logic [15:0] o_cnt_i,
    output logic [2:0]  o_state,
    output logic        o_done,
    output logic        o_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_END_OK  = 3'd2;
    localparam logic [2:0] S_END_OVF = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [15:0]   idx_q, idx_d;
    logic [15:0]   cnt_r_q, cnt_r_d;
    logic [15:0]   cnt_i_q, cnt_i_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    logic [1:0]    code_mem [FIFO_DEPTH];
    logic [15:0]   idx_mem  [FIFO_DEPTH];

    logic          live, ev, empty, full, pop, push;
    logic [AW:0]   occ;

    always_comb begin
        occ   = wr_ptr_q - rd_ptr_q;
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (occ == (AW + 1)'(FIFO_DEPTH));
        live  = (state_q == S_IDLE) || (state_q == S_RUN);
        ev    = i_status_valid && live;
        pop   = !empty && i_evt_ready;
        // A full FIFO still takes a push when the head leaves this cycle.
        push  = ev && (!full || pop);
    end

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        idx_d    = idx_q;
        cnt_r_d  = cnt_r_q;
        cnt_i_d  = cnt_i_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q | (i_status_valid && !live) | (ev && !push);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            idx_d    = idx_q + 16'd1;
            if (i_status == 2'd0 && cnt_r_q != 16'hFFFF) cnt_r_d = cnt_r_q + 16'd1;
            if (i_status == 2'd1 && cnt_i_q != 16'hFFFF) cnt_i_d = cnt_i_q + 16'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (i_status_valid) begin
                    idle_d = '0;
                    case (i_status)
                        2'd2:    state_d = S_END_OVF;
                        2'd3:    state_d = S_END_OK;
                        default: state_d = S_RUN;
                    endcase
                end
            end
            S_RUN: begin
                if (i_status_valid) begin
                    idle_d = '0;
                    if (i_status == 2'd2) state_d = S_END_OVF;
                    if (i_status == 2'd3) state_d = S_END_OK;
                end else begin
                    idle_d = idle_q + 1'b1;
                    // Count is about to reach TIMEOUT_CYC idle cycles.
                    if (idle_q == TW'(TIMEOUT_CYC - 1)) state_d = S_TIMEOUT;
                end
            end
            default: ;
        endcase

        done_d = (state_d == S_END_OK) || (state_d == S_END_OVF) ||
                 (state_d == S_TIMEOUT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            idle_q   <= '0;
            idx_q    <= '0;
            cnt_r_q  <= '0;
            cnt_i_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            idx_q    <= idx_d;
            cnt_r_q  <= cnt_r_d;
            cnt_i_q  <= cnt_i_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: head outputs are masked while empty.
    always_ff @(posedge i_clk) begin
        if (push) begin
            code_mem[wr_ptr_q[AW-1:0]] <= i_status;
            idx_mem[wr_ptr_q[AW-1:0]]  <= idx_q;
        end
    end

    assign o_evt_valid  = !empty;
    assign o_evt_status = empty ? 2'd0  : code_mem[rd_ptr_q[AW-1:0]];
    assign o_evt_idx    = empty ? 16'd0 : idx_mem[rd_ptr_q[AW-1:0]];
    assign o_cnt_r      = cnt_r_q;
    assign o_cnt_i      = cnt_i_q;
    assign o_state      = state_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
endmodule

// File: doc/status_monitor.md
STATUS_MONITOR -- requirements
Module: status_monitor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, idle cycles in RUN before timeout is declared.
REQ-003 SHALL have port i_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_status  input  2  core status code: 0 R-type, 1 I-type, 2 overflow, 3 end.
REQ-006 SHALL have port i_status_valid  input  1  i_status qualifier, one event per asserted cycle.
REQ-007 SHALL have port o_evt_valid  output  1  FIFO head valid.
REQ-008 SHALL have port i_evt_ready  input  1  downstream accepts head this cycle.
REQ-009 SHALL have port o_evt_status  output  2  status code at FIFO head.
REQ-010 SHALL have port o_evt_idx  output  16  sequence number of head event.
REQ-011 SHALL have port o_cnt_r  output  16  count of accepted R-type events.
REQ-012 SHALL have port o_cnt_i  output  16  count of accepted I-type events.
REQ-013 SHALL have port o_state  output  3  FSM state encoding.
REQ-014 SHALL have port o_done  output  1  run terminated (end, overflow or timeout).
REQ-015 SHALL have port o_err  output  1  sticky protocol error.

Function
REQ-016 SHALL implement FSM states IDLE=0, RUN=1, END_OK=2, END_OVF=3, TIMEOUT=4; o_state shows current state.
REQ-017 IDLE -> RUN on first i_status_valid of code 0/1; IDLE -> END_OK on code 3; IDLE -> END_OVF on code 2.
REQ-018 RUN -> END_OK on valid code 3; RUN -> END_OVF on valid code 2; RUN -> TIMEOUT when idle counter reaches TIMEOUT_CYC.
REQ-019 Idle counter SHALL clear on every i_status_valid and on entry to RUN, increment each RUN cycle without valid, not run in other states.
REQ-020 END_OK, END_OVF, TIMEOUT SHALL be terminal until reset; o_done=1 exactly in these states, registered (asserts the cycle after the terminating event).
REQ-021 In IDLE/RUN, each valid event SHALL be pushed as {code, idx} where idx is a 16-bit counter starting at 0, incremented per accepted event, wrapping FFFF->0000.
REQ-022 Terminating event (code 2 or 3) SHALL itself be pushed and counted in idx.
REQ-023 Any i_status_valid in a terminal state SHALL set o_err, not be pushed, not advance idx or counters.
REQ-024 FIFO full and push without same-cycle pop SHALL drop the event, set o_err, not advance idx or counters.
REQ-025 FIFO full with simultaneous pop and push SHALL accept both; occupancy unchanged.
REQ-026 Pop occurs when o_evt_valid & i_evt_ready; o_evt_valid=0 when empty; head outputs hold stable while o_evt_valid=1 and i_evt_ready=0.
REQ-027 Push-to-visible latency SHALL be 1 cycle (event in cycle N appears at head in N+1 if FIFO was empty); no combinational path from i_status to outputs.
REQ-028 o_cnt_r / o_cnt_i SHALL increment on accepted code 0 / 1 respectively and saturate at 16'hFFFF.
REQ-029 FIFO draining SHALL continue in terminal states; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 i_rst high SHALL immediately force: state IDLE, FIFO empty, o_evt_valid=0, o_evt_status=0, o_evt_idx=0, counters 0, idle counter 0, o_done=0, o_err=0.
REQ-031 Reset mid-run SHALL discard all queued events; first event after release gets idx 0.

Verification
REQ-032 Sequence 0,1,1,0,3 with i_evt_ready=1 -> heads idx0..4 codes 0,1,1,0,3; o_cnt_r=2, o_cnt_i=2; o_state=2, o_done=1 one cycle after code 3; o_err=0.
REQ-033 Code 0 then code 2 -> o_state=3, o_done=1; further valid code 0 -> o_err=1, o_cnt_r stays 1.
REQ-034 Code 0 then no valid for TIMEOUT_CYC cycles -> o_state=4, o_done=1; valid at cycle TIMEOUT_CYC-1 instead -> stays RUN.
REQ-035 i_evt_ready=0, 9 consecutive code-1 events (depth 8) -> 8 queued idx 0..7, 9th dropped, o_err=1, o_cnt_i=8; then full FIFO + ready=1 + new event -> accepted as idx 8.
REQ-036 i_rst pulse after 3 queued events -> o_evt_valid=0, counters 0, o_state=0 asynchronously; next event pops with idx 0.
